// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the breadboard CPU clock controller.
// The state encoding is visible on o_state and must not be reordered.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT       = 2'd0,
    STEP_CYCLE = 2'd1,
    STEP_INSTR = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_5MHZ = 50000;

  // Where a press in HALT leads, chosen by the mode switches.
  function automatic state_t haltExitState(input logic stepNRun, input logic instrNCycle);
    if (!stepNRun) return RUN;
    if (!instrNCycle) return STEP_CYCLE;
    return STEP_INSTR;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchronizer, saturating stability counter and a
// one-cycle press pulse on the accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_oszClk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] syncFf;
  logic                   syncLast;
  logic                   syncLevel;
  logic [CNT_W-1:0]       stableCnt;

  assign syncLevel = syncFf[SYNC_STAGES-1];

  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      syncFf    <= '0;
      syncLast  <= 1'b0;
      stableCnt <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
    end else begin
      syncFf[0] <= i_btn;
      for (int i = 1; i < SYNC_STAGES; i++) syncFf[i] <= syncFf[i-1];
      syncLast <= syncLevel;
      o_press  <= 1'b0;
      if (syncLevel != syncLast) begin
        stableCnt <= '0;
      end else if (stableCnt != CNT_MAX) begin
        stableCnt <= stableCnt + CNT_W'(1);
        // The level is taken on the same edge the counter reaches its limit.
        if (stableCnt == CNT_ACCEPT && o_level != syncLevel) begin
          o_level <= syncLevel;
          o_press <= syncLevel;
        end
      end
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Operator clock control for the breadboard CPU: run, cycle step,
// instruction step and breakpoint halt, gating the datapath clock enable.
//
// state      | meaning
// HALT       | datapath frozen, waiting for a step press
// STEP_CYCLE | one enabled cycle, then HALT
// STEP_INSTR | enabled until the current instruction ends, then HALT
// RUN        | free running until breakpoint or a switch/press to step
module clock_step_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_5MHZ,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        i_oszClk,
  input  logic        i_reset,
  input  logic        i_btnStep,
  input  logic        i_swStepNRun,
  input  logic        i_swInstrNCycle,
  input  logic        i_swEnableBreakpoint,
  input  logic [15:0] i_breakpointAddress,
  input  logic [15:0] i_pc,
  input  logic        i_instrEnd,
  output logic        o_cpuClkEn,
  output logic        o_halted,
  output logic [1:0]  o_state
);

  state_t state;
  logic   press;
  logic   unusedBtnLevel;
  logic   bpArm;
  logic   bpHit;
  logic   boundary;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) uStepDebounce (
    .i_oszClk(i_oszClk),
    .i_reset (i_reset),
    .i_btn   (i_btnStep),
    .o_level (unusedBtnLevel),
    .o_press (press)
  );

  assign bpHit = i_swEnableBreakpoint & bpArm & (i_pc == i_breakpointAddress);

  // A breakpoint hit suppresses the enable in the very cycle it is seen,
  // so the breakpoint instruction never starts.
  always_comb begin
    o_cpuClkEn = 1'b0;
    case (state)
      HALT:       o_cpuClkEn = 1'b0;
      STEP_CYCLE: o_cpuClkEn = 1'b1;
      STEP_INSTR: o_cpuClkEn = 1'b1;
      RUN:        o_cpuClkEn = ~bpHit;
      default:    o_cpuClkEn = 1'b0;
    endcase
  end

  assign boundary = o_cpuClkEn & i_instrEnd;
  assign o_halted = (state == HALT);
  assign o_state  = state;

  always_ff @(posedge i_oszClk) begin
    if (i_reset) begin
      state <= HALT;
      bpArm <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          if (press) begin
            state <= haltExitState(i_swStepNRun, i_swInstrNCycle);
            // Disarm so resuming at the breakpoint PC executes it.
            if (!i_swStepNRun) bpArm <= 1'b0;
          end
        end
        STEP_CYCLE: state <= HALT;
        STEP_INSTR: begin
          if (boundary) state <= HALT;
        end
        RUN: begin
          if (boundary) bpArm <= 1'b1;
          if (bpHit) begin
            state <= HALT;
          end else if (press || i_swStepNRun) begin
            state <= STEP_INSTR;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Scoreboard bench for clock_step_ctrl: expected enable bursts are queued as
// stimulus is issued and a monitor compares each burst as it ends.
module tb_clock_step_ctrl;
  import clock_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn = 1'b0;
  logic        swStepNRun = 1'b1;
  logic        swInstrNCycle = 1'b0;
  logic        swEnBp = 1'b0;
  logic [15:0] bpAddr = 16'h0000;
  logic [15:0] pc;
  logic        instrEnd;
  logic        cpuClkEn;
  logic        halted;
  logic [1:0]  state;

  always #5 clk = ~clk;

  clock_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .i_oszClk            (clk),
    .i_reset             (rst),
    .i_btnStep           (btn),
    .i_swStepNRun        (swStepNRun),
    .i_swInstrNCycle     (swInstrNCycle),
    .i_swEnableBreakpoint(swEnBp),
    .i_breakpointAddress (bpAddr),
    .i_pc                (pc),
    .i_instrEnd          (instrEnd),
    .o_cpuClkEn          (cpuClkEn),
    .o_halted            (halted),
    .o_state             (state)
  );

  // Control-unit / datapath model: three microcycles per instruction.
  int unsigned mc = 0;
  logic        loadReq = 1'b0;
  logic [15:0] loadPc = 16'h0000;

  assign instrEnd = (mc == 2);

  always @(posedge clk) begin
    if (loadReq) begin
      mc <= 0;
      pc <= loadPc;
    end else if (cpuClkEn === 1'b1) begin
      if (mc == 2) begin
        mc <= 0;
        pc <= pc + 16'd1;
      end else begin
        mc <= mc + 1;
      end
    end
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          len;
    logic [15:0] firstPc;
    logic [15:0] endPc;
    logic [1:0]  endState;
  } burst_t;

  burst_t expQ[$];

  task automatic pushBurst(input string tag, input int len, input logic [15:0] firstPc,
                           input logic [15:0] endPc, input logic [1:0] endState);
    burst_t b;
    b.tag = tag; b.len = len; b.firstPc = firstPc; b.endPc = endPc; b.endState = endState;
    expQ.push_back(b);
  endtask

  // Monitor: a burst is a run of enabled cycles; it is judged on its first idle cycle.
  int          monCnt = 0;
  logic [15:0] monFirstPc;

  initial begin
    burst_t e;
    forever begin
      @(negedge clk);
      if (cpuClkEn === 1'b1) begin
        if (monCnt == 0) monFirstPc = pc;
        monCnt++;
      end else if (monCnt > 0) begin
        if (expQ.size() == 0) begin
          check("unexpected_burst_len", monCnt, 0);
        end else begin
          e = expQ.pop_front();
          check($sformatf("%s_len", e.tag), monCnt, e.len);
          check($sformatf("%s_firstPc", e.tag), monFirstPc, e.firstPc);
          check($sformatf("%s_endPc", e.tag), pc, e.endPc);
          check($sformatf("%s_endState", e.tag), state, e.endState);
        end
        monCnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadCpu(input logic [15:0] p);
    loadPc  = p;
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
  endtask

  task automatic pressBtn();
    btn = 1'b1;
    tick(DEB + SYNC + 6);
    btn = 1'b0;
    tick(DEB + SYNC + 6);
  endtask

  task automatic waitHalted(input string tag, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_halted", tag), halted, 1'b1);
  endtask

  function automatic logic [15:0] singleEndPc();
    return (mc == 2) ? pc + 16'd1 : pc;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int enCnt;
    int firstEn;
    int seen;
    int n;
    int extra;
    int r;
    logic found;
    logic [15:0] p;

    // Reset state
    @(negedge clk);
    rst = 1'b1;
    loadCpu(16'h0100);
    tick(2);
    check("reset_clkEn", cpuClkEn, 1'b0);
    check("reset_halted", halted, 1'b1);
    check("reset_state", state, 2'd0);
    rst = 1'b0;
    tick(2);
    check("post_reset_state", state, 2'd0);

    // Bounce filtering in single-cycle step mode
    swStepNRun = 1'b1;
    swInstrNCycle = 1'b0;
    pushBurst("bounce", 1, pc, singleEndPc(), 2'd0);
    enCnt = 0;
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2) == 0;
      @(negedge clk);
      if (cpuClkEn === 1'b1) enCnt++;
    end
    check("bounce_no_early_en", enCnt, 0);
    btn = 1'b1;
    firstEn = -1;
    enCnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpuClkEn === 1'b1) begin
        enCnt++;
        if (firstEn < 0) firstEn = c;
      end
    end
    check("bounce_first_en_cycle", firstEn, 7);
    check("bounce_single_press", enCnt, 1);
    btn = 1'b0;
    tick(12);

    // Single-cycle steps
    for (int s = 0; s < 3; s++) begin
      tick($urandom_range(0, 5));
      pushBurst($sformatf("cycstep%0d", s), 1, pc, singleEndPc(), 2'd0);
      pressBtn();
      check($sformatf("cycstep%0d_halted_between", s), halted, 1'b1);
    end

    // Instruction step from whatever microcycle the cycle steps left behind
    swInstrNCycle = 1'b1;
    pushBurst("instr_partial", 3 - int'(mc), pc, pc + 16'd1, 2'd0);
    pressBtn();
    waitHalted("instr_partial", 20);

    // Instruction step from an instruction start
    loadCpu(16'($urandom));
    pushBurst("instr_full", 3, pc, pc + 16'd1, 2'd0);
    pressBtn();
    waitHalted("instr_full", 20);

    // Breakpoint halt: 8 instructions from 0x0020 before 0x0028 is blocked
    swStepNRun = 1'b0;
    swEnBp = 1'b1;
    bpAddr = 16'h0028;
    loadCpu(16'h0020);
    pushBurst("bp_halt", 3 * (16'h0028 - 16'h0020), 16'h0020, 16'h0028, 2'd3);
    pressBtn();
    waitHalted("bp_halt", 100);
    check("bp_halt_pc", pc, 16'h0028);
    tick(3);
    check("bp_stays_halted", state, 2'd0);

    // Resume at the breakpoint, then drain on switch to step mode
    n = $urandom_range(1, 10);
    seen = 0;
    found = 1'b0;
    btn = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (cpuClkEn === 1'b1) begin
        seen++;
        btn = 1'b0;
        if (seen == n) begin
          found = 1'b1;
          check("drain_state_run", state, 2'd3);
          extra = (mc == 2) ? 3 : 2 - int'(mc);
          pushBurst("drain", n + extra, 16'h0028, 16'h0028 + 16'((n + extra) / 3), 2'd0);
          swStepNRun = 1'b1;
        end
      end
    end
    btn = 1'b0;
    check("drain_reached", found, 1'b1);
    @(negedge clk);
    check("drain_state_step_instr", state, 2'd2);
    waitHalted("drain", 20);
    tick(12);

    // Reset in the middle of an instruction step
    swEnBp = 1'b0;
    swInstrNCycle = 1'b1;
    p = 16'($urandom);
    loadCpu(p);
    r = $urandom_range(1, 2);
    seen = 0;
    found = 1'b0;
    btn = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (cpuClkEn === 1'b1) begin
        seen++;
        if (seen == r) begin
          found = 1'b1;
          rst = 1'b1;
          btn = 1'b0;
          pushBurst("reset_mid", r, p, p, 2'd0);
        end
      end
    end
    check("reset_mid_reached", found, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check("reset_mid_clkEn", cpuClkEn, 1'b0);
    check("reset_mid_state", state, 2'd0);
    check("reset_mid_halted", halted, 1'b1);
    tick(12);

    // A press landing in the reset cycle is lost
    swInstrNCycle = 1'b0;
    btn = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    enCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpuClkEn === 1'b1) enCnt++;
    end
    check("reset_press_lost", enCnt, 0);
    check("reset_press_halted", halted, 1'b1);

    tick(10);
    check("scoreboard_empty", expQ.size(), 0);
    check("monitor_idle", monCnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
